// File: rtl/lsu_pkg.sv
// Shared op codes, FSM state encoding and exception codes for the LSU memory master.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/lsu_mem_master_load_ext.sv
// Lane selection plus sign/zero extension of a returned read word.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  op_code,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Half-word loads only look at lane[1]; the low address bit is not meaningful for them.
    assign byte_val = rdata[{lane, 3'b000} +: 8];
    assign half_val = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        result = rdata;
        case (op_code)
            OP_LB:   result = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  result = {24'd0, byte_val};
            OP_LH:   result = {{16{half_val[15]}}, half_val};
            OP_LHU:  result = {16'd0, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and data memory (req/gnt/rvalid, with timeout).
// Optional alignment exceptions are enabled by defining LSU_ALIGN_EXC_EN.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    output logic              res_valid,
    output logic [31:0]       res_data,
    output logic              res_err,
    output logic              res_exc,
    output logic [4:0]        res_exc_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [2:0]        op_q;
    logic [1:0]        lane_q;
    logic [15:0]       count_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       res_data_q;
    logic              res_err_q;
    logic              accept;
    logic              misaligned;
    logic              timeout_hit;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       load_result;

    assign accept      = op_valid && (state_q == ST_IDLE);
    assign timeout_hit = (count_q == 16'(TIMEOUT_CYCLES - 1));

`ifdef LSU_ALIGN_EXC_EN
    logic       res_exc_q;
    logic [4:0] res_exc_code_q;

    always_comb begin
        misaligned = 1'b0;
        case (op_code)
            OP_LW, OP_SW:         misaligned = (op_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = op_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_exc_q      <= 1'b0;
            res_exc_code_q <= 5'd0;
        end else if (accept) begin
            res_exc_q      <= misaligned;
            res_exc_code_q <= misaligned ? (is_load(op_code) ? EXC_ADEL : EXC_ADES) : 5'd0;
        end
    end

    assign res_exc      = res_exc_q;
    assign res_exc_code = res_exc_code_q;
`else
    assign misaligned   = 1'b0;
    assign res_exc      = 1'b0;
    assign res_exc_code = 5'd0;
`endif

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = 32'd0;
        case (op_code)
            OP_SW: wdata_d = op_wdata;
            OP_SH: begin
                be_d    = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{op_wdata[15:0]}};
            end
            OP_SB: begin
                be_d    = 4'b0001 << op_addr[1:0];
                wdata_d = {4{op_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_ext u_load_ext (
        .op_code (op_q),
        .lane    (lane_q),
        .rdata   (mem_rdata),
        .result  (load_result)
    );

    // A grant or read response in the final timeout cycle takes priority over the abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = misaligned ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (mem_gnt)          state_d = is_load(op_q) ? ST_WAIT : ST_DONE;
                else if (timeout_hit) state_d = ST_DONE;
            end
            ST_WAIT: if (mem_rvalid || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LW;
            lane_q     <= 2'b00;
            count_q    <= 16'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            res_data_q <= 32'd0;
            res_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= op_code;
                        lane_q     <= op_addr[1:0];
                        addr_q     <= {op_addr[ADDR_W-1:2], 2'b00};
                        we_q       <= !is_load(op_code);
                        be_q       <= be_d;
                        wdata_q    <= wdata_d;
                        res_data_q <= 32'd0;
                        res_err_q  <= 1'b0;
                        count_q    <= 16'd0;
                    end
                end
                ST_REQ: begin
                    count_q <= count_q + 16'd1;
                    if (!mem_gnt && timeout_hit) res_err_q <= 1'b1;
                end
                ST_WAIT: begin
                    count_q <= count_q + 16'd1;
                    if (mem_rvalid)       res_data_q <= load_result;
                    else if (timeout_hit) res_err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign res_valid = (state_q == ST_DONE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule
